// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial shifter with a one-word holding register, MSB first, no gap bits.
// Optional even-parity slot after each word when SERIAL_TX_PARITY_EN is defined.
module serial_tx_shifter #(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             bit_q, bit_d;
    logic             done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             load;
    logic             word_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_q       <= IDLE_BIT;
            done_q      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_q       <= bit_d;
            done_q      <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_d       = bit_q;
        done_d      = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d       = par_q;
`endif
        load        = 1'b0;
        word_end    = 1'b0;

        if (bit_en) begin
            case (state_q)
                S_IDLE: load = hold_full_q;
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        sh_d  = sh_q << 1;
                        bit_d = sh_q[WIDTH-2];
                        cnt_d = cnt_q - CW'(1);
                    end else begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
                        bit_d   = par_q;
`else
                        word_end = 1'b1;
`endif
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: word_end = 1'b1;
`endif
                default: state_d = S_IDLE;
            endcase

            // A finishing word chains straight into the held one so no idle bit appears.
            if (word_end) begin
                done_d = 1'b1;
                if (hold_full_q) begin
                    load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    bit_d   = IDLE_BIT;
                end
            end

            if (load) begin
                sh_d        = hold_q;
                bit_d       = hold_q[WIDTH-1];
                cnt_d       = CW'(WIDTH - 1);
                state_d     = S_SHIFT;
                hold_full_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                par_d       = ^hold_q;
`endif
            end
        end

        // Accept only when empty, so this never overlaps a load.
        if (s_valid && !hold_full_q) begin
            hold_d      = s_data;
            hold_full_d = 1'b1;
        end
    end

    assign s_ready   = !hold_full_q;
    assign bit_out   = bit_q;
    assign bit_valid = (state_q != S_IDLE);
    assign word_done = done_q;
    assign busy      = (state_q != S_IDLE) || hold_full_q;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Scoreboard bench for serial_tx_shifter: accepted words become expected bit slots,
// a monitor pops one slot per advancing bit edge and also checks word_done timing.
module tb_serial_tx_shifter;

    localparam int unsigned W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned SLOTS = W + 1;
`else
    localparam int unsigned SLOTS = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         bit_en;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready, bit_out, bit_valid, word_done, busy;

    serial_tx_shifter #(.WIDTH(W), .IDLE_BIT(1'b1)) dut (
        .clk(clk), .reset(reset), .bit_en(bit_en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .word_done(word_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic b; logic last; } slot_t;
    slot_t       exp_q[$];
    int unsigned done_cyc[$];
    int unsigned tests = 0, fails = 0;
    int unsigned cyc = 0;
    int unsigned en_mode = 0;
    logic        adv_q = 1'b0;
    logic        done_pend = 1'b0;
    logic        prev_bit = 1'b1, prev_valid = 1'b0;
    int unsigned run = 0, max_run = 0, vcount = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a word is its bits MSB first, then optionally its even parity.
    task automatic push_word(input logic [W-1:0] w);
        slot_t s;
        for (int i = W - 1; i >= 0; i--) begin
            s.b    = w[i];
            s.last = (i == 0) && (SLOTS == W);
            exp_q.push_back(s);
        end
        if (SLOTS != W) begin
            s.b    = ^w;
            s.last = 1'b1;
            exp_q.push_back(s);
        end
    endtask

    always @(posedge clk) begin
        adv_q <= bit_en;
        cyc   <= cyc + 1;
    end

    initial begin
        int unsigned ph = 0;
        bit_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (en_mode)
                0: bit_en = 1'b1;
                1: begin ph = (ph + 1) % 3; bit_en = (ph == 0); end
                default: bit_en = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor
    always @(negedge clk) begin
        slot_t s;
        logic  exp_done;
        if (reset) begin
            chk("rst_bit_out", bit_out, 1);
            chk("rst_bit_valid", bit_valid, 0);
            chk("rst_word_done", word_done, 0);
            chk("rst_s_ready", s_ready, 1);
            chk("rst_busy", busy, 0);
            exp_q.delete();
            done_pend  = 1'b0;
            prev_bit   = 1'b1;
            prev_valid = 1'b0;
        end else begin
            exp_done = done_pend && adv_q;
            if (exp_done) done_pend = 1'b0;
            chk("word_done", word_done, exp_done);
            if (word_done) done_cyc.push_back(cyc);
            if (adv_q) begin
                if (bit_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_bit", bit_valid, 0);
                    end else begin
                        s = exp_q.pop_front();
                        chk("bit_out", bit_out, s.b);
                        if (s.last) done_pend = 1'b1;
                    end
                end else begin
                    chk("idle_level", bit_out, 1);
                end
            end else begin
                chk("hold_bit", bit_out, prev_bit);
                chk("hold_valid", bit_valid, prev_valid);
            end
            chk("busy", busy, bit_valid || !s_ready);
            prev_bit   = bit_out;
            prev_valid = bit_valid;
        end
        if (bit_valid) begin
            run++;
            vcount++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic send(input logic [W-1:0] w);
        int unsigned n = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!s_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: s_ready still %0b after %0d cycles", s_ready, n);
        end else begin
            push_word(w);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || busy || word_done) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    task automatic idle_cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int unsigned i;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        idle_cycles(3);
        reset = 1'b0;

        // Idle after reset
        vcount = 0;
        idle_cycles(20);
        chk("idle_vcount", vcount, 0);
        chk("idle_s_ready", s_ready, 1);

        // 0x36 latency
        send(8'h36);
        s_valid = 1'b0;
        chk("lat_s_ready_after_accept", s_ready, 0);
        chk("lat_valid_before_load", bit_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_msb_valid", bit_valid, 1);
        chk("lat_msb_bit", bit_out, 0);
        chk("lat_s_ready_after_load", s_ready, 1);
        i = 0;
        while (!word_done && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("lat_word_done", i, SLOTS);
        drain();

        // Back-to-back stream
        max_run = 0;
        done_cyc.delete();
        send(8'hA5);
        send(8'h3C);
        send(8'hFF);
        s_valid = 1'b0;
        drain();
        chk("stream_run", max_run, 3 * SLOTS);
        chk("stream_dones", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            chk("stream_done_gap1", done_cyc[1] - done_cyc[0], SLOTS);
            chk("stream_done_gap2", done_cyc[2] - done_cyc[1], SLOTS);
        end

        // bit_en every third cycle
        en_mode = 1;
        idle_cycles(3);
        vcount = 0;
        send(8'h81);
        s_valid = 1'b0;
        drain();
        chk("slow_span", vcount, 3 * SLOTS);
        en_mode = 0;
        idle_cycles(2);

        // Reset mid-word with a word held
        send(8'hF0);
        send(8'h0F);
        s_valid = 1'b0;
        idle_cycles(3);
        chk("mid_valid_before_reset", bit_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_bit_out", bit_out, 1);
        chk("mid_reset_valid", bit_valid, 0);
        idle_cycles(2);
        reset = 1'b0;
        vcount = 0;
        idle_cycles(20);
        chk("mid_no_resume", vcount, 0);
        chk("mid_s_ready", s_ready, 1);

`ifdef SERIAL_TX_PARITY_EN
        done_cyc.delete();
        send(8'h07);
        send(8'h03);
        s_valid = 1'b0;
        drain();
        chk("par_dones", done_cyc.size(), 2);
        if (done_cyc.size() == 2) chk("par_done_gap", done_cyc[1] - done_cyc[0], 9);
`endif

        // Randomized traffic with random bit_en and source gaps
        en_mode = 2;
        for (int k = 0; k < 40; k++) begin
            send(W'($urandom));
            if ($urandom_range(2) == 0) begin
                s_valid = 1'b0;
                idle_cycles($urandom_range(12));
            end
        end
        s_valid = 1'b0;
        drain();
        en_mode = 0;
        idle_cycles(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
